// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Holds the scan FSM state enum, digit count, anode-off pattern and a helper.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [NUM_DIGITS-1:0] an_sel(input logic [1:0] idx);
        logic [NUM_DIGITS-1:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_seven_seg.sv
// Hex nibble to seven-segment decoder, combinational, active-high segments.
// Ports: nibble[3:0] in; seg[6:0] out as {g,f,e,d,c,b,a}.
module seg_scan_ctrl_seven_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        unique case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller with
// double-buffered digit data committed only at frame boundaries.
// Ports: clk, rst_n (sync, active-low), enable, load, digits_in[15:0],
//   dp_in[3:0], blank_in[3:0] in; seg_out[6:0], dp_out, an_out[3:0]
//   (active-low), frame_done out. All outputs registered.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  an_out,
    output logic        frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_cnt_nxt;
    logic [1:0]       digit;
    logic [1:0]       digit_nxt;
    logic             slot_end;
    logic             frame_wrap;

    logic [15:0] shd_digits;
    logic [3:0]  shd_dp;
    logic [3:0]  shd_blank;
    logic [15:0] act_digits;
    logic [3:0]  act_dp;
    logic [3:0]  act_blank;
    logic        pending;
    logic        commit;

    logic [3:0]  act_nibble;
    logic [6:0]  seg_dec;
    logic        show_on;

    // Scan FSM: state and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            slot_cnt <= '0;
            digit    <= 2'd0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_cnt_nxt;
            digit    <= digit_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        slot_cnt_nxt = slot_cnt;
        digit_nxt    = digit;
        frame_wrap   = 1'b0;
        slot_end     = (slot_cnt == CNT_MAX);
        if (!enable) begin
            state_nxt    = IDLE;
            slot_cnt_nxt = '0;
            digit_nxt    = 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Restart cleanly at digit 0, slot 0.
                    state_nxt    = BLANK;
                    slot_cnt_nxt = '0;
                    digit_nxt    = 2'd0;
                end
                BLANK: begin
                    slot_cnt_nxt = slot_end ? '0 : slot_cnt + 1'b1;
                    if (slot_cnt == BLANK_END) begin
                        state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        slot_cnt_nxt = '0;
                        digit_nxt    = digit + 2'd1;
                        state_nxt    = BLANK;
                        frame_wrap   = (digit == 2'd3);
                    end else begin
                        slot_cnt_nxt = slot_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    slot_cnt_nxt = '0;
                    digit_nxt    = 2'd0;
                end
            endcase
        end
    end

    // Shadow/active double buffer. A commit copies the shadow as it stood
    // before this cycle's load, so a coincident load stays pending.
    assign commit = pending && ((state == IDLE) || frame_wrap);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shd_digits <= '0;
            shd_dp     <= '0;
            shd_blank  <= '0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shd_digits <= digits_in;
                shd_dp     <= dp_in;
                shd_blank  <= blank_in;
            end
            if (commit) begin
                act_digits <= shd_digits;
                act_dp     <= shd_dp;
                act_blank  <= shd_blank;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Single shared decoder fed by the active-digit nibble.
    assign act_nibble = act_digits[{digit, 2'b00} +: 4];

    seg_scan_ctrl_seven_seg u_seven_seg (
        .nibble (act_nibble),
        .seg    (seg_dec)
    );

    // Dropping enable darkens the display on the very next edge.
    assign show_on = enable && (state == SHOW) && !act_blank[digit];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_out     <= AN_OFF;
            seg_out    <= 7'h00;
            dp_out     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an_out     <= show_on ? an_sel(digit) : AN_OFF;
            seg_out    <= show_on ? seg_dec : 7'h00;
            dp_out     <= show_on && act_dp[digit];
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (CLK_DIV=8, BLANK_CYC=2).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int n_cmp;
    int n_bad;
    int cur;

    seg_scan_ctrl #(
        .CLK_DIV   (8),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv_to(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an,
                           input logic [6:0] seg, input logic dp);
        chk({tag, ".an"}, {12'h0, an_out}, {12'h0, an});
        chk({tag, ".seg"}, {9'h0, seg_out}, {9'h0, seg});
        chk({tag, ".dp"}, {15'h0, dp_out}, {15'h0, dp});
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] exp_an;
        int s;
        int d;
        n_cmp     = 0;
        n_bad     = 0;
        cur       = -100;
        rst_n     = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'h0;
        blank_in  = 4'h0;
        repeat (2) @(negedge clk);
        chk_out("reset", 4'hF, 7'h00, 1'b0);
        chk("reset.fd", {15'h0, frame_done}, 16'h0);

        // Load while idle, then start scanning.
        rst_n     = 1'b1;
        load      = 1'b1;
        digits_in = 16'h4321;
        @(negedge clk);
        chk("idle.an", {12'h0, an_out}, 16'hF);
        load   = 1'b0;
        enable = 1'b1;
        cur    = -1;

        adv_to(0);
        chk("c0.an", {12'h0, an_out}, 16'hF);
        adv_to(2);
        chk("blank1.an", {12'h0, an_out}, 16'hF);
        adv_to(3);
        chk_out("d0.first", 4'hE, dec(4'h1), 1'b0);
        adv_to(8);
        chk_out("d0.last", 4'hE, dec(4'h1), 1'b0);
        adv_to(9);
        chk("d1.blank", {12'h0, an_out}, 16'hF);
        adv_to(11);
        chk_out("d1", 4'hD, dec(4'h2), 1'b0);
        adv_to(19);
        chk_out("d2", 4'hB, dec(4'h3), 1'b0);
        adv_to(27);
        chk_out("d3", 4'h7, dec(4'h4), 1'b0);
        adv_to(31);
        chk("fd.pre", {15'h0, frame_done}, 16'h0);
        adv_to(32);
        chk("fd.pulse", {15'h0, frame_done}, 16'h1);
        adv_to(33);
        chk("fd.post", {15'h0, frame_done}, 16'h0);
        adv_to(35);
        chk_out("f1.d0", 4'hE, dec(4'h1), 1'b0);

        // Load during digit 1: no tearing within the frame.
        adv_to(40);
        load      = 1'b1;
        digits_in = 16'hABCD;
        adv_to(41);
        load = 1'b0;
        adv_to(43);
        chk_out("tear.d1", 4'hD, dec(4'h2), 1'b0);
        adv_to(51);
        chk_out("tear.d2", 4'hB, dec(4'h3), 1'b0);
        adv_to(59);
        chk_out("tear.d3", 4'h7, dec(4'h4), 1'b0);
        adv_to(67);
        chk_out("new.d0", 4'hE, dec(4'hD), 1'b0);
        adv_to(75);
        chk_out("new.d1", 4'hD, dec(4'hC), 1'b0);
        adv_to(83);
        chk_out("new.d2", 4'hB, dec(4'hB), 1'b0);
        adv_to(91);
        chk_out("new.d3", 4'h7, dec(4'hA), 1'b0);
        adv_to(96);
        chk("fd.f2", {15'h0, frame_done}, 16'h1);

        // Blank digit 2, decimal point on digit 0.
        adv_to(97);
        load     = 1'b1;
        dp_in    = 4'b0001;
        blank_in = 4'b0100;
        adv_to(98);
        load = 1'b0;
        one  = 4'b0001;
        for (int c = 129; c <= 160; c++) begin
            adv_to(c);
            s = (c - 1) % 8;
            d = ((c - 1) / 8) % 4;
            exp_an = (s >= 2 && d != 2) ? ~(one << d) : 4'hF;
            chk("bl.an", {12'h0, an_out}, {12'h0, exp_an});
            chk("bl.dp", {15'h0, dp_out},
                {15'h0, (s >= 2 && d == 0)});
            chk("bl.fd", {15'h0, frame_done},
                {15'h0, ((c - 1) % 32 == 31)});
        end

        // Enable dropped at slot 5 of digit 2, load pending.
        adv_to(170);
        load      = 1'b1;
        digits_in = 16'h5678;
        dp_in     = 4'h0;
        blank_in  = 4'h0;
        adv_to(171);
        load = 1'b0;
        chk_out("f5.d1", 4'hD, dec(4'hC), 1'b0);
        adv_to(181);
        chk("f5.d2blk", {12'h0, an_out}, 16'hF);
        enable = 1'b0;
        adv_to(182);
        chk_out("drop", 4'hF, 7'h00, 1'b0);
        adv_to(184);
        chk("drop.fd", {15'h0, frame_done}, 16'h0);
        adv_to(185);
        enable = 1'b1;
        adv_to(188);
        chk("re.blank", {12'h0, an_out}, 16'hF);
        adv_to(189);
        chk_out("re.d0", 4'hE, dec(4'h8), 1'b0);
        adv_to(197);
        chk_out("re.d1", 4'hD, dec(4'h7), 1'b0);

        // Load on the wrap cycle defers by one frame.
        adv_to(200);
        load      = 1'b1;
        digits_in = 16'h3333;
        adv_to(201);
        load = 1'b0;
        adv_to(205);
        chk_out("re.d2", 4'hB, dec(4'h6), 1'b0);
        adv_to(217);
        load      = 1'b1;
        digits_in = 16'h7777;
        adv_to(218);
        load = 1'b0;
        chk("re.fd", {15'h0, frame_done}, 16'h1);
        adv_to(221);
        chk_out("wrap.prior", 4'hE, dec(4'h3), 1'b0);
        adv_to(253);
        chk_out("wrap.new", 4'hE, dec(4'h7), 1'b0);

        // Reset mid-SHOW, with a load that must be ignored.
        adv_to(254);
        rst_n     = 1'b0;
        load      = 1'b1;
        digits_in = 16'hFFFF;
        adv_to(255);
        load = 1'b0;
        chk_out("rst.mid", 4'hF, 7'h00, 1'b0);
        chk("rst.fd", {15'h0, frame_done}, 16'h0);
        adv_to(256);
        chk("rst.fd2", {15'h0, frame_done}, 16'h0);
        rst_n = 1'b1;
        adv_to(260);
        chk_out("post.rst", 4'hE, dec(4'h0), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 8, clock cycles per digit slot; legal range is 4 or more.
REQ-002 Parameter BLANK_CYC, default 2, leading cycles of each slot with all digits dark; BLANK_CYC < CLK_DIV SHALL hold.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  1 = scan running, 0 = display dark.
REQ-006 load  input  1  1-cycle strobe; captures digits_in/dp_in/blank_in into shadow.
REQ-007 digits_in  input  16  four hex nibbles; [3:0] = digit 0.
REQ-008 dp_in  input  4  per-digit decimal point request.
REQ-009 blank_in  input  4  per-digit blank (digit dark for its whole slot).
REQ-010 seg_out  output  7  segment drive from the shared decoder, active-high.
REQ-011 dp_out  output  1  decimal point drive, active-high.
REQ-012 an_out  output  4  digit select, active-low, one-hot-low or all-high.
REQ-013 frame_done  output  1  1-cycle pulse at each digit 3 -> 0 wrap.

Function
REQ-014 Slot counter SHALL count 0..CLK_DIV-1 and wrap; digit index (2 bits) SHALL advance 0->1->2->3->0 on each wrap.
REQ-015 FSM states: IDLE, BLANK, SHOW; IDLE->BLANK when enable=1; BLANK->SHOW when slot counter = BLANK_CYC-1; SHOW->BLANK when slot counter = CLK_DIV-1; any state->IDLE when enable=0.
REQ-016 In IDLE, slot counter and digit index SHALL be held at 0.
REQ-017 In BLANK and IDLE, an_out = 4'b1111, seg_out = 0, dp_out = 0.
REQ-018 In SHOW, an_out SHALL drive low only the bit of the current digit; seg_out = decoded active nibble; dp_out = active dp bit.
REQ-019 In SHOW, a digit with its active blank bit set SHALL behave as BLANK (anodes all high) for the whole slot.
REQ-020 All outputs SHALL be registered; outputs reflect the FSM/counter state of the previous cycle (latency 1).
REQ-021 load=1 SHALL write the shadow registers and set a pending flag.
REQ-022 Shadow SHALL commit to the active registers, and pending SHALL clear, on the cycle the digit index wraps 3->0, or on any cycle in IDLE.
REQ-023 load coincident with a commit: the commit takes the pre-load shadow contents, the new data enters shadow, and pending stays set.
REQ-024 Active registers SHALL never change mid-frame while enable=1; no tearing.
REQ-025 frame_done SHALL pulse for the 1 cycle after the 3->0 wrap only; it SHALL NOT pulse in IDLE.
REQ-026 enable falling mid-slot: IDLE on the next cycle; shadow and pending are preserved.
REQ-027 enable rising: scan SHALL restart at digit 0, slot counter 0, in BLANK.

Reset
REQ-028 With rst_n=0 at an edge: state IDLE, counters 0, shadow and active = 0, pending 0, an_out = 4'b1111, seg_out = 0, dp_out = 0, frame_done = 0.
REQ-029 Reset SHALL override load and enable in the same cycle.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, NUM_DIGITS=4, and the AN_OFF=4'b1111 constant.
REQ-031 Exactly one seven_seg instance SHALL be time-shared across all four digits through an active-nibble mux.

Verification (CLK_DIV=8, BLANK_CYC=2)
REQ-032 Reset, enable=1, load digits_in=16'h4321 -> digit 0 shows after 2 dark cycles; an_out=1110 for 6 cycles with seg_out = decode(1), then an_out=1101 with seg_out = decode(2), and so on.
REQ-033 load 16'hABCD during digit 1 -> digits 1-3 keep old values; new values appear from the next digit 0 slot; frame_done pulses once per 32 cycles.
REQ-034 blank_in=4'b0100, dp_in=4'b0001 -> an_out never 1011; dp_out=1 only while an_out=1110.
REQ-035 enable dropped at slot count 5 of digit 2 -> an_out=1111 next cycle; re-enable -> digit 0 BLANK, with any pending load already committed.
REQ-036 load asserted on the wrap cycle -> the following frame shows the prior shadow, and the new data appears one frame later.
REQ-037 rst_n low mid-SHOW -> all outputs at reset values the next cycle; frame_done stays 0.
